button_event_decoder: RTL and testbench

- Consumes a clean, debounced, clock-synchronous button level and decodes it into single-cycle event pulses: press, release, short click, long press and auto-repeat.
- Sits directly downstream of the debounce stage. It drives UI/control logic that needs discrete events instead of a raw level.
- Pure synchronous FSM plus counters, with no input synchronizer. The input is guaranteed synchronous and bounce-free.

---
 rtl/button_event_decoder.sv | 210 +++++++++++++++++++++
 tb/tb_button_event_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// Decodes a clean, synchronous button level into press/release/short/long/repeat pulses.
// Optional double-click detection is built when BUTTON_EVENT_DOUBLE_CLICK_EN is defined.
module button_event_decoder #(
   parameter int LONG_CNT   = 50_000_000,
   parameter int REPEAT_CNT = 10_000_000,
   parameter int DCLICK_WIN = 12_500_000
) (
   input  logic clkIn,
   input  logic rstNIn,
   input  logic enIn,
   input  logic buttonIn,
   output logic pressOut,
   output logic releaseOut,
   output logic shortOut,
   output logic longOut,
   output logic repeatOut,
   output logic heldOut,
   output logic doubleOut
);

   localparam int MAX_AB  = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
   localparam int MAX_CNT = (MAX_AB > DCLICK_WIN) ? MAX_AB : DCLICK_WIN;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      PRESSED,
      LONG_HELD
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
      , WAIT_SECOND
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
   logic             prev_q, prev_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             short_q, short_d;
   logic             long_q, long_d;
   logic             repeat_q, repeat_d;
   logic             held_q, held_d;
   logic             rise;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
   localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(DCLICK_WIN - 1);
   logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
   logic             second_q, second_d;
   logic             double_q, double_d;
`endif

   assign rise = buttonIn & ~prev_q;

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      rep_cnt_d  = rep_cnt_q;
      prev_d     = buttonIn;
      press_d    = 1'b0;
      release_d  = 1'b0;
      short_d    = 1'b0;
      long_d     = 1'b0;
      repeat_d   = 1'b0;
      held_d     = held_q;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
      win_cnt_d  = win_cnt_q;
      second_d   = second_q;
      double_d   = 1'b0;
`endif
      if (!enIn) begin
         // prev_d still follows buttonIn so a held button is not seen as a press on enable
         state_d    = IDLE;
         hold_cnt_d = '0;
         rep_cnt_d  = '0;
         held_d     = 1'b0;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
         win_cnt_d  = '0;
         second_d   = 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (rise) begin
                  press_d    = 1'b1;
                  held_d     = 1'b1;
                  hold_cnt_d = '0;
                  state_d    = PRESSED;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
                  second_d   = 1'b0;
`endif
               end
            end
            PRESSED: begin
               if (!buttonIn) begin
                  release_d  = 1'b1;
                  held_d     = 1'b0;
                  hold_cnt_d = '0;
                  state_d    = IDLE;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
                  // a first short click defers its shortOut until the window expires
                  if (!second_q) begin
                     state_d   = WAIT_SECOND;
                     win_cnt_d = '0;
                  end
                  second_d = 1'b0;
`else
                  short_d = 1'b1;
`endif
               end else if (hold_cnt_q == LONG_LAST) begin
                  long_d     = 1'b1;
                  rep_cnt_d  = '0;
                  hold_cnt_d = hold_cnt_q + CNT_ONE;
                  state_d    = LONG_HELD;
               end else begin
                  hold_cnt_d = hold_cnt_q + CNT_ONE;
               end
            end
            LONG_HELD: begin
               if (!buttonIn) begin
                  release_d  = 1'b1;
                  held_d     = 1'b0;
                  hold_cnt_d = '0;
                  rep_cnt_d  = '0;
                  state_d    = IDLE;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
                  second_d   = 1'b0;
`endif
               end else if (rep_cnt_q == REP_LAST) begin
                  repeat_d  = 1'b1;
                  rep_cnt_d = '0;
               end else begin
                  rep_cnt_d = rep_cnt_q + CNT_ONE;
               end
            end
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
            WAIT_SECOND: begin
               if (rise) begin
                  press_d    = 1'b1;
                  double_d   = 1'b1;
                  held_d     = 1'b1;
                  hold_cnt_d = '0;
                  win_cnt_d  = '0;
                  second_d   = 1'b1;
                  state_d    = PRESSED;
               end else if (win_cnt_q == WIN_LAST) begin
                  short_d   = 1'b1;
                  win_cnt_d = '0;
                  state_d   = IDLE;
               end else begin
                  win_cnt_d = win_cnt_q + CNT_ONE;
               end
            end
`endif
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clkIn or negedge rstNIn) begin
      if (!rstNIn) begin
         state_q    <= IDLE;
         hold_cnt_q <= '0;
         rep_cnt_q  <= '0;
         prev_q     <= 1'b1;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         short_q    <= 1'b0;
         long_q     <= 1'b0;
         repeat_q   <= 1'b0;
         held_q     <= 1'b0;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
         win_cnt_q  <= '0;
         second_q   <= 1'b0;
         double_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         rep_cnt_q  <= rep_cnt_d;
         prev_q     <= prev_d;
         press_q    <= press_d;
         release_q  <= release_d;
         short_q    <= short_d;
         long_q     <= long_d;
         repeat_q   <= repeat_d;
         held_q     <= held_d;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
         win_cnt_q  <= win_cnt_d;
         second_q   <= second_d;
         double_q   <= double_d;
`endif
      end
   end

   assign pressOut   = press_q;
   assign releaseOut = release_q;
   assign shortOut   = short_q;
   assign longOut    = long_q;
   assign repeatOut  = repeat_q;
   assign heldOut    = held_q;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
   assign doubleOut  = double_q;
`else
   assign doubleOut  = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: vector table, reset corner case, and random run
// against an event-level reference model (LONG_CNT=8, REPEAT_CNT=3, DCLICK_WIN=5).
module tb_button_event_decoder;

   localparam int L = 8;
   localparam int R = 3;
   localparam int W = 5;

   // expected-output bit positions: {press, release, short, long, repeat, held, double}
   localparam logic [6:0] P  = 7'b1000000;
   localparam logic [6:0] RL = 7'b0100000;
   localparam logic [6:0] S  = 7'b0010000;
   localparam logic [6:0] LG = 7'b0001000;
   localparam logic [6:0] RP = 7'b0000100;
   localparam logic [6:0] H  = 7'b0000010;
   localparam logic [6:0] D  = 7'b0000001;
   localparam logic [6:0] NONE = 7'b0000000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b1;
   logic btn = 1'b0;
   logic press_o, release_o, short_o, long_o, repeat_o, held_o, double_o;

   button_event_decoder #(.LONG_CNT(L), .REPEAT_CNT(R), .DCLICK_WIN(W)) dut (
      .clkIn(clk), .rstNIn(rst_n), .enIn(en), .buttonIn(btn),
      .pressOut(press_o), .releaseOut(release_o), .shortOut(short_o),
      .longOut(long_o), .repeatOut(repeat_o), .heldOut(held_o), .doubleOut(double_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic       btn;
      logic [6:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   // reference model: tracks press start time and release time, derives events arithmetically
   int   tick, t0, tr;
   bit   m_prev, m_pressing, m_pending, m_second, m_held;
   logic [6:0] m_exp;

   function automatic logic [6:0] outs();
      return {press_o, release_o, short_o, long_o, repeat_o, held_o, double_o};
   endfunction

   function automatic void model_reset();
      tick = 0; t0 = 0; tr = 0;
      m_prev = 1'b1; m_pressing = 1'b0; m_pending = 1'b0; m_second = 1'b0; m_held = 1'b0;
      m_exp = NONE;
   endfunction

   function automatic void model_step(input bit e, input bit b);
      int d;
      logic [6:0] ev;
      ev = NONE;
      if (!e) begin
         m_pressing = 1'b0; m_pending = 1'b0; m_second = 1'b0; m_held = 1'b0;
      end else if (m_pressing) begin
         d = tick - t0;
         if (!b) begin
            ev = ev | RL;
            m_held = 1'b0;
            m_pressing = 1'b0;
            if (d <= L && !m_second) begin
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
               m_pending = 1'b1;
               tr = tick;
`else
               ev = ev | S;
`endif
            end
            m_second = 1'b0;
         end else if (d == L) begin
            ev = ev | LG;
         end else if (d > L && ((d - L) % R) == 0) begin
            ev = ev | RP;
         end
      end else if (m_pending && b && !m_prev) begin
         ev = ev | P | D;
         m_held = 1'b1; m_pressing = 1'b1; m_second = 1'b1; m_pending = 1'b0;
         t0 = tick;
      end else if (m_pending && (tick - tr) == W) begin
         ev = ev | S;
         m_pending = 1'b0;
      end else if (b && !m_prev) begin
         ev = ev | P;
         m_held = 1'b1; m_pressing = 1'b1; m_second = 1'b0;
         t0 = tick;
      end
      m_exp = ev | (m_held ? H : NONE);
      m_prev = b;
      tick++;
   endfunction

   task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b required %b (press,release,short,long,repeat,held,double)",
                  name, got, exp);
      end
   endtask

   task automatic step(input bit e, input bit b, output logic [6:0] got);
      en = e;
      btn = b;
      @(posedge clk);
      model_step(e, b);
      @(negedge clk);
      got = outs();
   endtask

   function automatic void add(input logic e, input logic b, input logic [6:0] exp);
      vecs.push_back('{en: e, btn: b, exp: exp});
   endfunction

   function automatic void add_hold(input int n);
      for (int k = 0; k < n; k++) add(1'b1, 1'b1, H);
   endfunction

   initial begin
      logic [6:0] got;
      bit b;
      bit e;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_state", outs(), NONE);
      rst_n = 1'b1;

`ifndef BUTTON_EVENT_DOUBLE_CLICK_EN
      // short press of 4 edges
      add(1, 0, NONE); add(1, 1, P | H); add_hold(3); add(1, 0, RL | S); add(1, 0, NONE);
      // exactly LONG_CNT edges is still short
      add(1, 1, P | H); add_hold(7); add(1, 0, RL | S); add(1, 0, NONE);
      // LONG_CNT+1 edges is long
      add(1, 1, P | H); add_hold(7); add(1, 1, LG | H); add(1, 0, RL); add(1, 0, NONE);
      // 15-edge hold with two repeats
      add(1, 1, P | H); add_hold(7); add(1, 1, LG | H); add_hold(2); add(1, 1, RP | H);
      add_hold(2); add(1, 1, RP | H); add(1, 0, RL); add(1, 0, NONE);
      // back-to-back presses
      add(1, 1, P | H); add_hold(2); add(1, 0, RL | S); add(1, 1, P | H); add(1, 1, H);
      add(1, 0, RL | S);
      // enabling while held gives no press
      add(0, 1, NONE); add(0, 1, NONE); add(1, 1, NONE); add(1, 1, NONE); add(1, 0, NONE);
      // press aborted by enIn=0 emits no release
      add(1, 1, P | H); add(1, 1, H); add(0, 1, NONE); add(1, 1, NONE); add(1, 0, NONE);
`else
      // double click: two 2-edge presses, second press 3 edges after release
      add(1, 0, NONE); add(1, 1, P | H); add(1, 1, H); add(1, 0, RL); add(1, 0, NONE);
      add(1, 0, NONE); add(1, 1, P | H | D); add(1, 1, H); add(1, 0, RL);
      for (int k = 0; k < 7; k++) add(1, 0, NONE);
      // single click: shortOut five edges after release
      add(1, 1, P | H); add(1, 1, H); add(1, 0, RL);
      for (int k = 0; k < 4; k++) add(1, 0, NONE);
      add(1, 0, S); add(1, 0, NONE);
      // second press on the last window edge still counts
      add(1, 1, P | H); add(1, 0, RL);
      for (int k = 0; k < 4; k++) add(1, 0, NONE);
      add(1, 1, P | H | D); add(1, 0, RL); add(1, 0, NONE);
      // disabling during the window drops the pending short
      add(1, 1, P | H); add(1, 0, RL); add(0, 0, NONE);
      for (int k = 0; k < 7; k++) add(1, 0, NONE);
`endif

      foreach (vecs[i]) begin
         step(vecs[i].en, vecs[i].btn, got);
         check($sformatf("vec%0d", i), got, vecs[i].exp);
      end

      // async reset in the middle of a long hold, released while still held
      step(1, 1, got);
      check("hold_press", got, P | H);
      for (int k = 1; k < 10; k++) begin
         step(1, 1, got);
         check($sformatf("hold_d%0d", k), got, m_exp);
      end
      #2 rst_n = 1'b0;
      #1 check("rst_async", outs(), NONE);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step(1, 1, got);
         check($sformatf("rst_held%0d", k), got, NONE);
      end
      step(1, 0, got);
      check("rst_release", got, NONE);

      // randomized run against the model
      b = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         e = ($urandom_range(0, 39) != 0);
         if ($urandom_range(0, 5) == 0) b = ~b;
         step(e, b, got);
         check($sformatf("rand%0d", i), got, m_exp);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
